// File: rtl/histo_readout_seq_if.sv
// Output stream of histo_readout_seq: one bin count per valid/ready handshake
// toward the transport/FIFO stage.
interface histo_readout_seq_if;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_last;
  logic [9:0]  out_bin;

  modport master (output out_valid, output out_data, output out_last, output out_bin,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_last, input  out_bin,
                  output out_ready);
endinterface

// File: rtl/histo_readout_seq.sv
// Histogram readout sequencer: on frame completion, sweeps every accumulator bin in
// read (clear-on-read) mode and streams the counts out, tracking a per-frame sum.
module histo_readout_seq #(
  parameter int unsigned NBINS    = 1024,
  parameter int unsigned READ_LAT = 3,
  parameter int unsigned TAIL     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       histo_done_i,
  output logic                       rw_o,
  output logic [9:0]                 bin_o,
  input  logic [23:0]                histo_data_i,
  histo_readout_seq_if.master        strm,
  output logic                       busy_o,
  output logic [7:0]                 frame_cnt_o,
  output logic [33:0]                sum_total_o,
  output logic                       overrun_o,
  input  logic                       clr_overrun_i
);

  localparam int unsigned BW = 10;
  localparam int unsigned DW = 24;
  localparam int unsigned SW = 34;
  localparam int unsigned FW = 8;
  localparam int unsigned LW = 3;
  localparam int unsigned TW = (TAIL > 1) ? $clog2(TAIL) : 1;
  localparam logic [BW-1:0] LAST_BIN = BW'(NBINS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_PUSH, S_TAIL} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   wait_q, wait_d;
  logic [TW-1:0]   tail_q, tail_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [SW-1:0]   sum_total_q, sum_total_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic            rw_q, rw_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_last_q, out_last_d;
  logic [BW-1:0]   out_bin_q, out_bin_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    tail_d      = tail_q;
    sum_d       = sum_q;
    sum_total_d = sum_total_q;
    frame_d     = frame_q;
    rw_d        = rw_q;
    bin_d       = bin_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_bin_d   = out_bin_q;

    case (state_q)
      S_IDLE: begin
        if (histo_done_i) begin
          state_d = S_ADDR;
          idx_d   = '0;
          sum_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_ADDR: begin
        rw_d    = 1'b0;
        bin_d   = idx_q;
        wait_d  = LW'(READ_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          out_data_d  = histo_data_i;
          out_bin_d   = idx_q;
          out_last_d  = (idx_q == LAST_BIN);
          out_valid_d = 1'b1;
          sum_d       = sum_q + {{(SW-DW){1'b0}}, histo_data_i};
          state_d     = S_PUSH;
        end else begin
          wait_d = wait_q - LW'(1);
        end
      end
      S_PUSH: begin
        // Address is held under backpressure; only a handshake advances the sweep
        if (strm.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            tail_d  = TW'(TAIL - 1);
            state_d = S_TAIL;
          end else begin
            idx_d   = idx_q + BW'(1);
            state_d = S_ADDR;
          end
        end
      end
      S_TAIL: begin
        if (tail_q == '0) begin
          sum_total_d = sum_q;
          frame_d     = frame_q + FW'(1);
          busy_d      = 1'b0;
          rw_d        = 1'b1;
          bin_d       = '0;
          state_d     = S_IDLE;
        end else begin
          tail_d = tail_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky overrun: a set in the same cycle as a clear takes priority
  always_comb begin
    overrun_d = overrun_q;
    if (histo_done_i && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else if (clr_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      tail_q      <= '0;
      sum_q       <= '0;
      sum_total_q <= '0;
      frame_q     <= '0;
      rw_q        <= 1'b1;
      bin_q       <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_bin_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      tail_q      <= tail_d;
      sum_q       <= sum_d;
      sum_total_q <= sum_total_d;
      frame_q     <= frame_d;
      rw_q        <= rw_d;
      bin_q       <= bin_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_bin_q   <= out_bin_d;
    end
  end

  assign rw_o           = rw_q;
  assign bin_o          = bin_q;
  assign busy_o         = busy_q;
  assign frame_cnt_o    = frame_q;
  assign sum_total_o    = sum_total_q;
  assign overrun_o      = overrun_q;
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;
  assign strm.out_last  = out_last_q;
  assign strm.out_bin   = out_bin_q;

endmodule

// File: tb/tb_histo_readout_seq.sv
// Bench for histo_readout_seq: accumulator memory model, expected-word queue and
// per-frame sum model; a second small instance covers frame counter wrap.
module tb_histo_readout_seq;

  localparam int unsigned NB = 1024;

  typedef struct packed {
    logic [23:0] d;
    logic [9:0]  b;
  } word_t;

  logic        clk = 1'b0;
  logic        rst, histo_done, clr_overrun, rw, busy, overrun;
  logic [9:0]  bin;
  logic [23:0] histo_data;
  logic [7:0]  frame_cnt;
  logic [33:0] sum_total;

  logic        done2, rw2, busy2, overrun2;
  logic [9:0]  bin2;
  logic [23:0] histo_data2;
  logic [7:0]  frame_cnt2;
  logic [33:0] sum_total2;

  histo_readout_seq_if sif ();
  histo_readout_seq_if sif2 ();

  histo_readout_seq #(.NBINS(1024), .READ_LAT(3), .TAIL(4)) dut (
    .clk(clk), .rst(rst), .histo_done_i(histo_done), .rw_o(rw), .bin_o(bin),
    .histo_data_i(histo_data), .strm(sif), .busy_o(busy), .frame_cnt_o(frame_cnt),
    .sum_total_o(sum_total), .overrun_o(overrun), .clr_overrun_i(clr_overrun)
  );

  histo_readout_seq #(.NBINS(4), .READ_LAT(1), .TAIL(1)) dut_small (
    .clk(clk), .rst(rst), .histo_done_i(done2), .rw_o(rw2), .bin_o(bin2),
    .histo_data_i(histo_data2), .strm(sif2), .busy_o(busy2), .frame_cnt_o(frame_cnt2),
    .sum_total_o(sum_total2), .overrun_o(overrun2), .clr_overrun_i(1'b0)
  );

  always #5 clk = ~clk;

  // Accumulator model: count for a bin appears READ_LAT (3) cycles after the bin changes
  logic [23:0] mem [NB];
  logic [9:0]  bin_d1, bin_d2;
  always @(posedge clk) begin
    bin_d1 <= bin;
    bin_d2 <= bin_d1;
  end
  assign histo_data  = mem[bin_d2];
  assign histo_data2 = 24'(bin2) + 24'd7;

  int          n_vec = 0;
  int          n_err = 0;
  word_t       exp_q[$];
  logic [33:0] exp_sum;
  int          exp_frames = 0;
  bit          mon_en = 1'b0;
  int          rdy_mode = 0;
  int          stall_left = 0;
  bit          stall_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every word presented must match the head of the expected queue, held until accepted
  always @(negedge clk) begin
    if (mon_en && !rst && sif.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 64'(sif.out_valid), 64'd0);
      end else begin
        chk("out_data", 64'(sif.out_data), 64'(exp_q[0].d));
        chk("out_bin",  64'(sif.out_bin),  64'(exp_q[0].b));
        chk("out_last", 64'(sif.out_last), 64'(exp_q[0].b == 10'd1023));
        chk("bin_hold", 64'(bin),          64'(exp_q[0].b));
        chk("rw_read",  64'(rw),           64'd0);
        if (sif.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Downstream ready: always-on, or 30% random with one 8-cycle stall on bin 511
  initial begin
    sif.out_ready  = 1'b1;
    sif2.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        sif.out_ready = 1'b1;
      end else if (stall_left > 0) begin
        stall_left--;
        sif.out_ready = 1'b0;
        if (stall_left == 0) begin
          chk("stall_data", 64'(sif.out_data), 64'(mem[511]));
          chk("stall_bin",  64'(bin),          64'd511);
        end
      end else if (!stall_done && sif.out_valid && sif.out_bin == 10'd511) begin
        stall_done    = 1'b1;
        stall_left    = 7;
        sif.out_ready = 1'b0;
      end else begin
        sif.out_ready = ($urandom_range(99, 0) < 30);
      end
    end
  end

  task automatic load_exp();
    exp_q.delete();
    exp_sum = '0;
    for (int b = 0; b < NB; b++) begin
      exp_q.push_back({mem[b], 10'(b)});
      exp_sum += 34'(mem[b]);
    end
  endtask

  task automatic run_sweep(input bit chk_len);
    int cnt;
    bit timeout;
    load_exp();
    mon_en = 1'b1;
    @(posedge clk); #1; histo_done = 1'b1;
    @(posedge clk); #1; histo_done = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    cnt = 1;
    timeout = 1'b1;
    for (int k = 0; k < 60000; k++) begin
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
      cnt++;
      @(posedge clk); #1;
      if (k == 0) begin
        chk("rw_low_first", 64'(rw),  64'd0);
        chk("bin_first",    64'(bin), 64'd0);
      end
    end
    chk("sweep_timeout", 64'(timeout), 64'd0);
    exp_frames = (exp_frames + 1) % 256;
    chk("frame_cnt",  64'(frame_cnt), 64'(exp_frames));
    chk("sum_total",  64'(sum_total), 64'(exp_sum));
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("rw_idle",    64'(rw),  64'd1);
    chk("bin_idle",   64'(bin), 64'd0);
    chk("valid_idle", 64'(sif.out_valid), 64'd0);
    if (chk_len) chk("sweep_len", 64'(cnt), 64'd5125);
    mon_en = 1'b0;
  endtask

  task automatic sweep_small();
    bit timeout;
    @(posedge clk); #1; done2 = 1'b1;
    @(posedge clk); #1; done2 = 1'b0;
    timeout = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (!busy2) begin
        timeout = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    chk("small_timeout", 64'(timeout), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [33:0] small_sum;
    bit          hit;
    rst = 1'b1; histo_done = 1'b0; clr_overrun = 1'b0; done2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rw",      64'(rw),            64'd1);
    chk("rst_busy",    64'(busy),          64'd0);
    chk("rst_valid",   64'(sif.out_valid), 64'd0);
    chk("rst_frame",   64'(frame_cnt),     64'd0);
    chk("rst_sum",     64'(sum_total),     64'd0);
    chk("rst_overrun", 64'(overrun),       64'd0);
    chk("rst_bin",     64'(bin),           64'd0);
    rst = 1'b0;

    // Full sweep, no backpressure
    for (int b = 0; b < NB; b++) mem[b] = 24'(b + 5);
    rdy_mode = 0;
    run_sweep(1'b1);
    chk("sum_528896", 64'(sum_total), 64'd528896);
    chk("no_overrun", 64'(overrun), 64'd0);

    // Random backpressure with a long stall on bin 511
    rdy_mode = 1; stall_done = 1'b0;
    run_sweep(1'b0);
    rdy_mode = 0;
    chk("stall_seen", 64'(stall_done), 64'd1);
    chk("bp_sum", 64'(sum_total), 64'd528896);

    // Overrun at bin 100, with a simultaneous clear that must lose
    hit = 1'b0;
    fork
      run_sweep(1'b0);
      begin
        for (int k = 0; k < 20000; k++) begin
          @(negedge clk);
          if (bin == 10'd100) begin
            hit = 1'b1;
            break;
          end
        end
        chk("ovr_reach", 64'(hit), 64'd1);
        @(posedge clk); #1; histo_done = 1'b1; clr_overrun = 1'b1;
        @(posedge clk); #1; histo_done = 1'b0; clr_overrun = 1'b0;
        chk("ovr_set_wins", 64'(overrun), 64'd1);
      end
    join
    chk("ovr_sticky", 64'(overrun), 64'd1);
    @(posedge clk); #1; clr_overrun = 1'b1;
    @(posedge clk); #1; clr_overrun = 1'b0;
    chk("ovr_clear", 64'(overrun), 64'd0);

    // Saturated bins
    for (int b = 0; b < NB; b++) mem[b] = 24'hFF_FFFF;
    run_sweep(1'b0);
    chk("sum_max", 64'(sum_total), 64'h3_FFFF_FC00);

    // Reset while bin 300 sits in PUSH
    for (int b = 0; b < NB; b++) mem[b] = 24'($urandom);
    @(posedge clk); #1; histo_done = 1'b1;
    @(posedge clk); #1; histo_done = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (sif.out_valid && sif.out_bin == 10'd300) begin
        hit = 1'b1;
        break;
      end
    end
    chk("mid_reach", 64'(hit), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rw",    64'(rw),            64'd1);
    chk("mid_valid", 64'(sif.out_valid), 64'd0);
    chk("mid_busy",  64'(busy),          64'd0);
    chk("mid_bin",   64'(bin),           64'd0);
    chk("mid_obin",  64'(sif.out_bin),   64'd0);
    chk("mid_frame", 64'(frame_cnt),     64'd0);
    chk("mid_sum",   64'(sum_total),     64'd0);
    rst = 1'b0;
    exp_frames = 0;
    run_sweep(1'b1);

    // Frame counter wrap on a 4-bin instance
    small_sum = '0;
    for (int b = 0; b < 4; b++) small_sum += 34'(b + 7);
    for (int k = 1; k <= 256; k++) begin
      sweep_small();
      chk("small_frame", 64'(frame_cnt2), 64'(k % 256));
      if (k == 1 || k == 256) chk("small_sum", 64'(sum_total2), 64'(small_sum));
    end
    chk("frame_wrap", 64'(frame_cnt2), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/histo_readout_seq.md
# histo_readout_seq

Readout sequencer that sits directly downstream of the histogram accumulator. When a frame's histogram is complete, it takes control of the accumulator's read/write and bin-select lines and sweeps all 1024 bins. It captures each bin's 24-bit count and streams the counts out over a valid/ready interface to the transport/FIFO stage. Because the accumulator clears each bin as it is read in read mode, the sweep also leaves the histogram empty for the next frame.

## Interface
Parameters:
- NBINS, 1024: number of bins swept; the bin index is 10 bits wide.
- READ_LAT, 3: cycles from a `bin` change to a valid `histo_data`; legal range 1–7.
- TAIL, 4: cycles `rw` stays low after the last capture, so the clear-on-read writes drain.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- histo_done  in  1  one-cycle pulse from the accumulator: frame complete.
- rw  out  1  accumulator mode; 1 = accumulate/write, 0 = readout.
- bin  out  10  bin index presented to the accumulator.
- histo_data  in  24  count for the currently selected bin.
- out_valid  out  1  `out_data` holds a valid bin count.
- out_ready  in  1  downstream accepts the word on `out_valid & out_ready`.
- out_data  out  24  bin count.
- out_last  out  1  high with the word for bin NBINS-1.
- out_bin  out  10  bin index of `out_data`.
- busy  out  1  high from sweep start until return to IDLE.
- frame_cnt  out  8  number of completed sweeps; wraps modulo 256.
- sum_total  out  34  sum of all bin counts in the last completed sweep.
- overrun  out  1  sticky flag: `histo_done` arrived while `busy`.
- clr_overrun  in  1  clears `overrun`.

## Operation
- States: IDLE, ADDR, WAIT, PUSH, TAIL.
- IDLE
  - Outputs: `rw`=1, `bin`=0, `busy`=0.
  - On `histo_done`: go to ADDR, clear the bin index and the sum accumulator, set `busy`=1.
- ADDR
  - Drive `rw`=0 and `bin`=index.
  - Load the wait counter with READ_LAT-1 and go to WAIT.
  - `rw` stays 0 from here through TAIL.
- WAIT
  - Decrement the wait counter.
  - When it reaches 0, register `histo_data` into `out_data`, `index` into `out_bin`, and `index==NBINS-1` into `out_last`.
  - On that same capture, add `histo_data` (zero-extended to 34 bits) into the sum.
  - Then go to PUSH.
- PUSH
  - Hold `out_valid`=1 with data stable until `out_ready`.
  - On the handshake with `out_last`=0: increment the index and go to ADDR.
  - On the handshake with `out_last`=1: go to TAIL with the tail counter = TAIL-1.
  - `bin` holds its value throughout PUSH; backpressure never advances the address.
- TAIL
  - Count down with `rw`=0; `bin` holds NBINS-1.
  - At 0: copy the sum into `sum_total`, increment `frame_cnt`, go to IDLE.
- Arithmetic
  - The sum is 34 bits wide; it cannot overflow, since 1024 × (2^24−1) < 2^34.
  - The index is 10 bits; the `out_last` comparison uses NBINS-1, so the index never wraps.
- Overrun
  - `histo_done` in any state other than IDLE sets `overrun` and is otherwise ignored; no restart, no sweep abort.
  - `clr_overrun` clears the flag. If a set and a clear arrive in the same cycle, set wins.
- Reset (including mid-sweep)
  - State returns to IDLE; `rw`=1 on the next edge.
  - `out_valid`, `out_last`, `busy` and `overrun` = 0; `out_data`, `out_bin`, `bin` = 0.
  - `sum_total` = 0 and `frame_cnt` = 0.
  - A partially read histogram is not recovered; the accumulator's own reset clears it.

## Timing
- Every output is registered; there are no combinational paths from input to output.
- `histo_done` sampled at edge N → `busy`=1 and state ADDR after N; `rw`=0 and `bin`=0 after N+1.
- Per bin with no backpressure: 1 ADDR cycle + READ_LAT WAIT cycles + 1 PUSH cycle = READ_LAT+2 cycles.
  - Full sweep = 1024·(READ_LAT+2) + TAIL + 1 cycles, which is 5125 with the defaults.
- Data capture happens exactly READ_LAT edges after `bin` changes.
- `out_valid` never deasserts without a handshake; `out_data`, `out_bin` and `out_last` stay stable while `out_valid` is high.
- The bin-to-bin `bin` change is always at least READ_LAT+2 cycles apart, so each new index is observed as a change.
- `sum_total` and `frame_cnt` update on the same edge that `busy` falls.

## Test plan
- Reset values: assert `rst` 3 cycles → `rw`=1, `busy`=0, `out_valid`=0, `frame_cnt`=0, `sum_total`=0, `overrun`=0.
- Full sweep, no backpressure:
  - Stimulus: a memory model returns `histo_data`=bin+5 after READ_LAT, with `out_ready` tied to 1.
  - Required response:
    - 1024 words with `out_data`=bin+5, in order 0..1023.
    - `out_last` only on bin 1023.
    - `sum_total`=528 896; `frame_cnt`=1.
    - Sweep length 5125 cycles.
- Backpressure:
  - Stimulus: `out_ready` random at 30% duty, plus an 8-cycle stall on bin 511.
  - Required response: `out_data` and `bin` stable throughout the stall, no lost or duplicated bins, same `sum_total` as the no-backpressure sweep.
- Overrun: pulse `histo_done` at bin 100 → `overrun`=1, sweep completes unaffected, `frame_cnt` increments by 1 only; `clr_overrun` → `overrun`=0.
- Max counts and wrap:
  - Stimulus: all bins = 0xFFFFFF.
  - Required response: `sum_total`=0x3_FFFF_FC00.
  - Run 256 sweeps → `frame_cnt` wraps to 0.
- Reset mid-sweep: assert `rst` while at bin 300 in PUSH → IDLE next edge, `rw`=1, `out_valid`=0; a following `histo_done` starts again at bin 0.
